// File: rtl/spi_ram_ctrl.sv
// SPI-attached RAM controller: decodes 10-bit command words from an SPI slave
// into address/data operations on a local 8-bit memory.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       seq_err
);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Edge detector: rx_q is the last rx_valid sample, rise_q flags the first
    // high sample, go_q launches execution one cycle later. din is expected
    // to stay stable while rx_valid is high, so it is used directly.
    logic                 rx_q;
    logic                 rise_q;
    logic                 go_q;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_vld;
    logic                 rd_vld;

    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           opcode_c;
    logic                 do_write_c;

    assign opcode_c   = din[9:8];
    assign do_write_c = go_q && (opcode_c == OP_WR_DATA) && wr_vld;

    // Command sequencing, pointer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q     <= 1'b0;
            rise_q   <= 1'b0;
            go_q     <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_vld   <= 1'b0;
            rd_vld   <= 1'b0;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            rx_q     <= rx_valid;
            rise_q   <= rx_valid && !rx_q;
            go_q     <= rise_q;
            tx_valid <= 1'b0;
            seq_err  <= 1'b0;
            if (go_q) begin
                case (opcode_c)
                    OP_WR_ADDR: begin
                        wr_addr <= din[ADDR_SIZE-1:0];
                        wr_vld  <= 1'b1;
                    end
                    OP_WR_DATA: begin
                        if (wr_vld) begin
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    OP_RD_ADDR: begin
                        rd_addr <= din[ADDR_SIZE-1:0];
                        rd_vld  <= 1'b1;
                    end
                    OP_RD_DATA: begin
                        if (rd_vld) begin
                            dout     <= mem[rd_addr];
                            tx_valid <= 1'b1;
                            rd_addr  <= rd_addr + ADDR_SIZE'(1);
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_write_c) begin
            mem[wr_addr] <= din[7:0];
        end
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8: address width; SHALL satisfy 2**ADDR_SIZE == MEM_DEPTH and ADDR_SIZE <= 8.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  10  command word from SPI slave; [9:8] opcode, [7:0] payload.
REQ-006 rx_valid  input  1  din valid; may stay high for several cycles per word.
REQ-007 dout  output  8  read data returned to SPI slave.
REQ-008 tx_valid  output  1  single-cycle pulse marking a new dout value.
REQ-009 seq_err  output  1  single-cycle pulse flagging a rejected data command.

Function
REQ-010 The block SHALL act on a command only in the cycle after rx_valid is first sampled high following a sampled low (registered rising-edge detect), so each SPI word executes exactly once however long rx_valid stays high.
REQ-011 Opcode 2'b00 (write address): wr_addr SHALL load din[ADDR_SIZE-1:0] and wr_vld SHALL set to 1.
REQ-012 Opcode 2'b01 (write data): with wr_vld=1, mem[wr_addr] SHALL load din[7:0] and wr_addr SHALL increment by 1.
REQ-013 Opcode 2'b10 (read address): rd_addr SHALL load din[ADDR_SIZE-1:0] and rd_vld SHALL set to 1.
REQ-014 Opcode 2'b11 (read data): with rd_vld=1, dout SHALL load mem[rd_addr], tx_valid SHALL pulse high for exactly one cycle in that same cycle, and rd_addr SHALL increment by 1; din[7:0] is ignored.
REQ-015 Command latency: memory write or dout/tx_valid update SHALL occur on the 2nd rising edge after the edge at which rx_valid is first sampled high.
REQ-016 Address increment SHALL wrap modulo MEM_DEPTH (MEM_DEPTH-1 -> 0) with no flag.
REQ-017 dout SHALL hold its last value between reads; tx_valid SHALL be 0 in every cycle without a read-data execution.
REQ-018 Write data with wr_vld=0 SHALL suppress the write, leave wr_addr unchanged, and pulse seq_err for one cycle.
REQ-019 Read data with rd_vld=0 SHALL leave dout and rd_addr unchanged, keep tx_valid=0, and pulse seq_err for one cycle.
REQ-020 seq_err and tx_valid SHALL never both be 1 in the same cycle.
REQ-021 wr_addr/rd_addr and wr_vld/rd_vld SHALL be independent; write traffic SHALL NOT alter read state, and read traffic SHALL NOT alter write state.
REQ-022 A read of the address written in the same cycle cannot occur, because one command executes per cycle; a read after a write SHALL return the newly written data.
REQ-023 Internal state: edge-detect register, wr_addr, rd_addr, wr_vld, rd_vld, memory array; no other sequencing state.

Reset
REQ-024 When rst_n=0, dout=8'h00, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, wr_vld=0, rd_vld=0, and the edge-detect register=0 SHALL hold immediately, with no clock required.
REQ-025 Memory contents SHALL NOT be affected by reset.
REQ-026 If rx_valid is already high when rst_n deasserts, the word SHALL execute once; the edge detector SHALL treat the first post-reset sample as a rising edge.
REQ-027 Reset asserted between rx_valid rising and command execution SHALL abort the command: no memory write and no output pulse.

Verification
REQ-028 Write addr 0x3A, then write data 0xC5, then read addr 0x3A, then read data -> dout=0xC5, one tx_valid pulse, seq_err never high.
REQ-029 Write addr 0xFF, then write data 0x11 and 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); read addr 0xFF, then two reads -> dout 0x11 then 0x22.
REQ-030 After reset, issue read data (din=10'h300) -> seq_err pulses once, tx_valid stays 0, dout stays 0x00; write data 10'h155 -> seq_err pulses, memory unchanged.
REQ-031 Hold rx_valid high 12 cycles with din=10'h1AB after write addr 0x10 -> exactly one write, mem[0x10]=0xAB, mem[0x11] unchanged.
REQ-032 Write addr 0x05 and read addr 0x40 interleaved with data ops -> each pointer advances only on its own data commands.
REQ-033 Assert rst_n low mid-sequence after mem[0x20]=0x7E was written -> outputs and flags clear; read addr 0x20 plus read data then returns 0x7E.
